// File: rtl/packet_serializer.sv
// ============================================================================
// packet_serializer : buffers encoded packets and serializes one per token
//                     hold onto the ring link as LINK_W-bit flits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module packet_serializer #(
  parameter int PKT_W      = 55,
  parameter int LINK_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic              token_in,
  output logic              token_out,
  output logic [LINK_W-1:0] link_data,
  output logic              link_valid,
  output logic              link_sof,
  output logic              link_eof,
  input  logic              link_ready,
  output logic              token_err,
  output logic [7:0]        drop_cnt
);

  localparam int NUM_FLITS = (PKT_W + LINK_W - 1) / LINK_W;
  localparam int PAD_W     = NUM_FLITS * LINK_W - PKT_W;
  localparam int IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);

  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_FLITS - 1);
  localparam logic [AW:0]      C_DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_PASS    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [PKT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_handshake;
  logic             w_legal;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [PKT_W-1:0] w_head;
  logic [7:0]       r_drop_cnt;

  assign w_full      = (r_count == C_DEPTH_CNT);
  assign w_empty     = (r_count == '0);
  assign pkt_ready   = !w_full;
  assign w_handshake = pkt_valid && pkt_ready;
  assign w_legal     = (pkt_in[PKT_W-1 -: 3] == 3'b001) || (pkt_in[PKT_W-1 -: 3] == 3'b010);
  assign w_push      = w_handshake && w_legal;
  assign w_drop      = w_handshake && !w_legal;
  assign w_head      = r_mem[r_rd_ptr];
  assign drop_cnt    = r_drop_cnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pkt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // ------------------------------------------------------ flit slicing
  logic [NUM_FLITS*LINK_W-1:0] w_padded;
  logic [LINK_W-1:0]           w_flits [NUM_FLITS];

  if (PAD_W > 0) begin : g_pad
    assign w_padded = {w_head, {PAD_W{1'b0}}};
  end else begin : g_nopad
    assign w_padded = w_head;
  end

  // Flit 0 carries the packet MSBs.
  for (genvar g = 0; g < NUM_FLITS; g++) begin : g_flit
    assign w_flits[g] = w_padded[(NUM_FLITS-1-g)*LINK_W +: LINK_W];
  end

  // ---------------------------------------------------------------- FSM
  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_next_idx;
  logic [IDX_W-1:0]  w_idx_inc;
  logic [LINK_W-1:0] r_link_data;
  logic [LINK_W-1:0] w_next_data;
  logic              r_sof;
  logic              w_next_sof;
  logic              r_eof;
  logic              w_next_eof;
  logic              r_token_err;

  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign link_data  = r_link_data;
  assign link_sof   = r_sof;
  assign link_eof   = r_eof;
  assign link_valid = (r_state == S_SEND);
  assign token_out  = (r_state == S_PASS) || (r_state == S_RELEASE);
  assign token_err  = r_token_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_link_data <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_token_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_link_data <= w_next_data;
      r_sof       <= w_next_sof;
      r_eof       <= w_next_eof;
      if (token_in && (r_state != S_IDLE)) begin
        r_token_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_data  = r_link_data;
    w_next_sof   = r_sof;
    w_next_eof   = r_eof;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (token_in) begin
          if (!w_empty) begin
            w_next_state = S_SEND;
            w_next_idx   = '0;
            w_next_data  = w_flits[0];
            w_next_sof   = 1'b1;
            w_next_eof   = (C_LAST_IDX == '0);
          end else begin
            w_next_state = S_PASS;
          end
        end
      end
      S_SEND: begin
        // Head stays in the FIFO until its last flit is accepted.
        if (link_ready) begin
          if (r_idx == C_LAST_IDX) begin
            w_pop        = 1'b1;
            w_next_state = S_RELEASE;
            w_next_idx   = '0;
            w_next_data  = '0;
            w_next_sof   = 1'b0;
            w_next_eof   = 1'b0;
          end else begin
            w_next_idx  = w_idx_inc;
            w_next_data = w_flits[w_idx_inc];
            w_next_sof  = 1'b0;
            w_next_eof  = (w_idx_inc == C_LAST_IDX);
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
